// File: rtl/joystick_drive_ctrl_pkg.sv
// joystick_drive_ctrl_pkg: shared widths, constants and FSM state encoding for the joystick drive controller
//   ADC_W          joystick ADC code width
//   CMD_W          signed motor command width
//   SPEED_MAX      magnitude limit of a motor command
//   CENTRE_DEFAULT stick centre assumed until the first calibration completes
package joystick_drive_ctrl_pkg;
  localparam int ADC_W = 12;
  localparam int CMD_W = 9;
  localparam int SPEED_MAX = 255;
  localparam logic [ADC_W-1:0] CENTRE_DEFAULT = 12'd2048;
  typedef enum logic [2:0] {CAL_WAIT, CAL_ACC, RUN_IDLE, RUN_CALC, RUN_OFFER} state_e;
endpackage

// File: rtl/joystick_drive_ctrl_tick_gen.sv
// joystick_drive_ctrl_tick_gen: free-running sample-rate divider
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   tick_o  one-cycle pulse every SAMPLE_DIV cycles (while the counter sits at SAMPLE_DIV-1)
module joystick_drive_ctrl_tick_gen #(
  parameter int SAMPLE_DIV = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int W = $clog2(SAMPLE_DIV);
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(SAMPLE_DIV - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= tick_o ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/joystick_drive_ctrl.sv
// joystick_drive_ctrl: calibrates the stick centre and turns sampled X/Y axes into left/right drive commands
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   x_i, y_i       steering / throttle ADC codes (unsigned)
//   recal_i        one-cycle request to re-run calibration
//   cmd_ready_i    motor stage accepts the offered command
//   cmd_valid_o    left_cmd_o/right_cmd_o hold a command
//   left_cmd_o     signed left speed, -255..+255
//   right_cmd_o    signed right speed, -255..+255
//   cal_done_o     centre values are valid
//   overrun_cnt_o  saturating count of ticks dropped while a command was pending
module joystick_drive_ctrl
  import joystick_drive_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV = 500000,
  parameter int CAL_LOG2 = 4,
  parameter int DEADZONE = 80
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADC_W-1:0]        x_i,
  input  logic [ADC_W-1:0]        y_i,
  input  logic                    recal_i,
  input  logic                    cmd_ready_i,
  output logic                    cmd_valid_o,
  output logic signed [CMD_W-1:0] left_cmd_o,
  output logic signed [CMD_W-1:0] right_cmd_o,
  output logic                    cal_done_o,
  output logic [7:0]              overrun_cnt_o
);
  localparam int ACC_W = ADC_W + CAL_LOG2;
  localparam logic signed [ADC_W:0] DZ = (ADC_W + 1)'(DEADZONE);
  function automatic logic signed [9:0] axis_speed(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] c);
    logic signed [ADC_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, c});
    return (d < DZ && d > -DZ) ? '0 : 10'(d >>> 3);
  endfunction
  // sum/difference is formed at 11 bits so +-511 cannot wrap before clamping
  function automatic logic signed [CMD_W-1:0] mix_sat(input logic signed [9:0] a, input logic signed [9:0] b,
                                                      input logic sub);
    logic signed [10:0] v;
    v = sub ? 11'(a) - 11'(b) : 11'(a) + 11'(b);
    return v > 11'(SPEED_MAX) ? CMD_W'(SPEED_MAX) : v < -11'(SPEED_MAX) ? -CMD_W'(SPEED_MAX) : v[CMD_W-1:0];
  endfunction
  state_e state_q;
  logic tick;
  logic recal_q, cmd_valid_q, cal_done_q;
  logic [ADC_W-1:0] xc_q, yc_q, xs_q, ys_q;
  logic [ACC_W-1:0] xacc_q, yacc_q, xsum_d, ysum_d;
  logic [CAL_LOG2-1:0] nsamp_q;
  logic signed [CMD_W-1:0] left_q, right_q;
  logic [7:0] ovr_q;
  logic signed [9:0] sx_d, sy_d;
  logic go_cal_d;
  joystick_drive_ctrl_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tick_o(tick)
  );
  // a pending recal is honoured in calibration and idle; a pending command must be accepted first
  always_comb begin
    sx_d = axis_speed(xs_q, xc_q);
    sy_d = axis_speed(ys_q, yc_q);
    xsum_d = xacc_q + ACC_W'(x_i);
    ysum_d = yacc_q + ACC_W'(y_i);
    go_cal_d = (recal_q | recal_i) &
               ((state_q inside {CAL_WAIT, CAL_ACC, RUN_IDLE}) | (state_q == RUN_OFFER & cmd_ready_i));
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= CAL_WAIT;
      recal_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cal_done_q <= 1'b0;
      xc_q <= CENTRE_DEFAULT;
      yc_q <= CENTRE_DEFAULT;
      xs_q <= '0;
      ys_q <= '0;
      xacc_q <= '0;
      yacc_q <= '0;
      nsamp_q <= '0;
      left_q <= '0;
      right_q <= '0;
      ovr_q <= '0;
    end else begin
      if (recal_i) recal_q <= 1'b1;
      if (go_cal_d) begin
        state_q <= CAL_WAIT;
        recal_q <= 1'b0;
        cmd_valid_q <= 1'b0;
        cal_done_q <= 1'b0;
        xacc_q <= '0;
        yacc_q <= '0;
        nsamp_q <= '0;
      end else
        case (state_q)
          CAL_WAIT: if (tick) state_q <= CAL_ACC;
          CAL_ACC: if (tick) begin
            nsamp_q <= nsamp_q + CAL_LOG2'(1);
            if (&nsamp_q) begin
              xc_q <= xsum_d[ACC_W-1:CAL_LOG2];
              yc_q <= ysum_d[ACC_W-1:CAL_LOG2];
              xacc_q <= '0;
              yacc_q <= '0;
              cal_done_q <= 1'b1;
              state_q <= RUN_IDLE;
            end else begin
              xacc_q <= xsum_d;
              yacc_q <= ysum_d;
            end
          end
          RUN_IDLE: if (tick) begin
            xs_q <= x_i;
            ys_q <= y_i;
            state_q <= RUN_CALC;
          end
          RUN_CALC: begin
            left_q <= mix_sat(sy_d, sx_d, 1'b0);
            right_q <= mix_sat(sy_d, sx_d, 1'b1);
            cmd_valid_q <= 1'b1;
            state_q <= RUN_OFFER;
          end
          RUN_OFFER: if (cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            state_q <= tick ? RUN_CALC : RUN_IDLE;
            if (tick) begin
              xs_q <= x_i;
              ys_q <= y_i;
            end
          end else if (tick && !(&ovr_q)) ovr_q <= ovr_q + 8'd1;
          default: state_q <= CAL_WAIT;
        endcase
    end
  assign cmd_valid_o = cmd_valid_q;
  assign left_cmd_o = left_q;
  assign right_cmd_o = right_q;
  assign cal_done_o = cal_done_q;
  assign overrun_cnt_o = ovr_q;
endmodule

// File: tb/tb_joystick_drive_ctrl.sv
// tb_joystick_drive_ctrl: directed and random stimulus checked against a transaction-level model of the controller
module tb_joystick_drive_ctrl;
  localparam int SD = 8;
  localparam int CL = 2;
  localparam int DZ = 80;
  localparam int NCAL = 1 << CL;
  logic clk = 1'b0, rst_n = 1'b0, recal = 1'b0, ready = 1'b1;
  logic [11:0] x = 12'd2048, y = 12'd2048;
  logic cmd_valid, cal_done;
  logic signed [8:0] left_cmd, right_cmd;
  logic [7:0] ovr_o;
  int npass = 0, ntot = 0, cyc = 0;
  int tc = 0, m_ovr = 0, m_cx = 2048, m_cy = 2048, m_l = 0, m_r = 0, m_sx = 0, m_sy = 0;
  bit m_cal = 0, m_settled = 0, m_valid = 0, m_snap = 0, m_latch = 0;
  int qx[$], qy[$];
  joystick_drive_ctrl #(.SAMPLE_DIV(SD), .CAL_LOG2(CL), .DEADZONE(DZ)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .x_i          (x),
    .y_i          (y),
    .recal_i      (recal),
    .cmd_ready_i  (ready),
    .cmd_valid_o  (cmd_valid),
    .left_cmd_o   (left_cmd),
    .right_cmd_o  (right_cmd),
    .cal_done_o   (cal_done),
    .overrun_cnt_o(ovr_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  function automatic int spd(int a, int c);
    int d = a - c;
    if (d > -DZ && d < DZ) d = 0;
    return d >= 0 ? d / 8 : -((7 - d) / 8);
  endfunction
  function automatic int sat(int v);
    return v > 255 ? 255 : v < -255 ? -255 : v;
  endfunction
  function automatic int pick(int c);
    int k = int'($urandom_range(0, 2));
    int v = k == 0 ? int'($urandom_range(0, 4095)) :
            k == 1 ? c + int'($urandom_range(0, 240)) - 120 : int'($urandom_range(0, 1)) * 4095;
    return v < 0 ? 0 : v > 4095 ? 4095 : v;
  endfunction
  task automatic chk(string n, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  // model: calibration as a sample list, run mode as "snapshot taken" / "command offered"
  initial forever begin : mdl
    bit tk, rs;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      tc = 0; m_ovr = 0; m_cx = 2048; m_cy = 2048; m_l = 0; m_r = 0;
      m_cal = 0; m_settled = 0; m_valid = 0; m_snap = 0; m_latch = 0;
      qx.delete(); qy.delete();
    end else begin
      tk = tc == SD - 1;
      tc = tk ? 0 : tc + 1;
      if (recal) m_latch = 1;
      rs = 0;
      if (!m_cal) begin
        if (m_latch) rs = 1;
        else if (tk && !m_settled) m_settled = 1;
        else if (tk) begin
          qx.push_back(int'(x));
          qy.push_back(int'(y));
          if (qx.size() == NCAL) begin
            m_cx = qx.sum() / NCAL;
            m_cy = qy.sum() / NCAL;
            m_cal = 1;
            qx.delete(); qy.delete();
          end
        end
      end else if (m_valid) begin
        if (ready) begin
          m_valid = 0;
          if (m_latch) rs = 1;
          else if (tk) begin m_sx = int'(x); m_sy = int'(y); m_snap = 1; end
        end else if (tk && m_ovr < 255) m_ovr++;
      end else if (m_snap) begin
        m_l = sat(spd(m_sy, m_cy) + spd(m_sx, m_cx));
        m_r = sat(spd(m_sy, m_cy) - spd(m_sx, m_cx));
        m_valid = 1;
        m_snap = 0;
      end else if (m_latch) rs = 1;
      else if (tk) begin m_sx = int'(x); m_sy = int'(y); m_snap = 1; end
      if (rs) begin
        m_cal = 0; m_settled = 0; m_latch = 0; m_snap = 0;
        qx.delete(); qy.delete();
      end
    end
  end
  always @(negedge clk) begin
    chk("valid", int'(cmd_valid), int'(m_valid));
    chk("cal_done", int'(cal_done), int'(m_cal));
    chk("overrun", int'(ovr_o), m_ovr);
    chk("left", int'(left_cmd), m_l);
    chk("right", int'(right_cmd), m_r);
  end
  task automatic wait_valid();
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("valid_timeout", 0, 1);
  endtask
  task automatic wait_cal();
    int n = 0;
    while (cal_done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("cal_timeout", 0, 1);
  endtask
  task automatic get_cmd(string n, int el, int er);
    repeat (10) @(negedge clk);
    wait_valid();
    chk({n, "_left"}, int'(left_cmd), el);
    chk({n, "_right"}, int'(right_cmd), er);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cal();
    chk("cal_done_cycle", cyc, 40);
    wait_valid();
    chk("first_valid_cycle", cyc, 49);
    chk("first_left", int'(left_cmd), 0);
    chk("first_right", int'(right_cmd), 0);
    @(negedge clk); #1 y = 12'd2848;
    get_cmd("fwd", 100, 100);
    #1 y = 12'd1988;
    get_cmd("deadzone", 0, 0);
    #1 x = 12'd4095; y = 12'd4095;
    get_cmd("sat_left", 255, 0);
    #1 x = 12'd0;
    get_cmd("sat_right", -1, 255);
    #1 x = 12'd2048; y = 12'd2848;
    repeat (10) @(negedge clk);
    #1 ready = 1'b0;
    wait_valid();
    #1 x = 12'd0; y = 12'd0;
    repeat (24) @(negedge clk);
    chk("overrun3", int'(ovr_o), 3);
    chk("hold_left", int'(left_cmd), 100);
    chk("hold_valid", int'(cmd_valid), 1);
    repeat (2400) @(negedge clk);
    chk("overrun_sat", int'(ovr_o), 255);
    while ((cyc + 1) % SD != 0) @(negedge clk);
    #1 ready = 1'b1; x = 12'd2048; y = 12'd1248;
    @(negedge clk);
    chk("accept_tick_valid0", int'(cmd_valid), 0);
    @(negedge clk);
    chk("accept_tick_valid1", int'(cmd_valid), 1);
    chk("accept_tick_left", int'(left_cmd), -100);
    chk("accept_tick_right", int'(right_cmd), -100);
    #1 x = 12'd2100; y = 12'd2100;
    repeat (10) @(negedge clk);
    #1 ready = 1'b0;
    wait_valid();
    #1 recal = 1'b1;
    @(negedge clk); #1 recal = 1'b0;
    repeat (20) @(negedge clk);
    chk("recal_hold_cal", int'(cal_done), 1);
    #1 ready = 1'b1;
    @(negedge clk);
    chk("recal_drop_cal", int'(cal_done), 0);
    wait_cal();
    get_cmd("recal_centre", 0, 0);
    #1 y = 12'd2900;
    get_cmd("recal_fwd", 100, 100);
    #1 y = 12'd2148;
    get_cmd("recal_dz", 0, 0);
    #1 ready = 1'b0; y = 12'd2900;
    wait_valid();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_left", int'(left_cmd), 0);
    chk("rst_right", int'(right_cmd), 0);
    chk("rst_cal", int'(cal_done), 0);
    chk("rst_overrun", int'(ovr_o), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_cal();
    chk("rst_cal_cycle", cyc, 40);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1 ready = $urandom_range(0, 3) != 0;
      recal = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 15) == 0) begin
        x = 12'(pick(m_cx));
        y = 12'(pick(m_cy));
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
